// File: rtl/hdmi_infoframe_pkg.sv
// Shared constants, FSM state type and header helpers for the HDMI InfoFrame builder.
package hdmi_infoframe_pkg;

  localparam logic [6:0] IF_TYPE_AVI   = 7'd2;
  localparam logic [6:0] IF_TYPE_SPD   = 7'd3;
  localparam logic [6:0] IF_TYPE_AUDIO = 7'd4;

  // Both payload buffers are sized for the largest legal payload.
  localparam int unsigned PB_MAX = 27;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUM,
    ST_WAIT_SWAP
  } if_state_e;

  function automatic logic [23:0] infoframe_header(input logic [6:0] if_type,
                                                   input logic [7:0] version,
                                                   input logic [4:0] length);
    return {3'b000, length, version, 1'b1, if_type};
  endfunction

  function automatic logic [7:0] header_sum(input logic [6:0] if_type,
                                            input logic [7:0] version,
                                            input logic [4:0] length);
    return {1'b1, if_type} + version + {3'b000, length};
  endfunction

endpackage

// File: rtl/infoframe_checksum_engine.sv
// Serial 8-bit checksum accumulator: walks payload indices 1..LENGTH, one byte per clock.
module infoframe_checksum_engine
  import hdmi_infoframe_pkg::*;
#(
  parameter logic [4:0] LENGTH = 5'd25,
  parameter logic [7:0] HSUM   = 8'h00
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic [4:0] idx_o,
  output logic       last_o,
  output logic [7:0] acc_o
);

  logic       busy_q;
  logic [4:0] idx_q;
  logic [4:0] idx_d;
  logic [7:0] acc_q;
  logic [7:0] acc_d;
  logic       busy_d;

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    acc_d  = acc_q;
    if (start_i) begin
      busy_d = 1'b1;
      idx_d  = 5'd1;
      acc_d  = HSUM;
    end else if (busy_q) begin
      acc_d = acc_q + byte_i;
      if (idx_q == LENGTH) busy_d = 1'b0;
      else                 idx_d  = idx_q + 5'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      idx_q  <= 5'd1;
      acc_q  <= HSUM;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      acc_q  <= acc_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = busy_q && (idx_q == LENGTH);
  assign acc_o  = acc_q;

endmodule

// File: rtl/infoframe_builder.sv
// Runtime-updatable InfoFrame generator: shadow payload, serial checksum, atomic swap to active.
module infoframe_builder
  import hdmi_infoframe_pkg::*;
#(
  parameter logic [6:0] TYPE    = 7'd3,
  parameter logic [7:0] VERSION = 8'd1,
  parameter logic [4:0] LENGTH  = 5'd25
) (
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              commit,
  output logic              commit_ready,
  input  logic              swap_enable,
  output logic              wr_dropped,
  output logic              updated,
  output logic [23:0]       header,
  output logic [3:0][55:0]  sub
);

  if ((LENGTH < 5'd1) || (LENGTH > 5'd27)) begin : g_bad_length
    $error("infoframe_builder: LENGTH must be in 1..27");
  end

  localparam logic [7:0] HSUM      = header_sum(TYPE, VERSION, LENGTH);
  localparam logic [7:0] RESET_PB0 = 8'd0 - HSUM;

  if_state_e  state_q;
  logic       commit_ready_q;
  logic       updated_q;
  logic       wr_dropped_q;
  logic [7:0] pb0_q;
  logic [7:0] shadow_q [1:PB_MAX];
  logic [7:0] active_q [1:PB_MAX];

  logic       wr_addr_ok;
  logic       sum_start;
  logic       sum_last;
  logic [4:0] sum_idx;
  logic [7:0] sum_byte;
  logic [7:0] sum_acc;

  assign wr_addr_ok = (wr_addr != 5'd0) && (wr_addr <= LENGTH);
  assign sum_start  = (state_q == ST_IDLE) && commit;

  always_comb begin
    sum_byte = 8'h00;
    for (int n = 1; n <= PB_MAX; n++) begin
      if (sum_idx == 5'(n)) sum_byte = shadow_q[n];
    end
  end

  infoframe_checksum_engine #(
    .LENGTH (LENGTH),
    .HSUM   (HSUM)
  ) u_checksum (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .start_i   (sum_start),
    .byte_i    (sum_byte),
    .idx_o     (sum_idx),
    .last_o    (sum_last),
    .acc_o     (sum_acc)
  );

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      commit_ready_q <= 1'b1;
      updated_q      <= 1'b0;
      wr_dropped_q   <= 1'b0;
      pb0_q          <= RESET_PB0;
      // NOTE: both payload buffers are reset because a reset must publish an all-zero payload with a valid checksum.
      for (int n = 1; n <= PB_MAX; n++) begin
        shadow_q[n] <= 8'h00;
        active_q[n] <= 8'h00;
      end
    end else begin
      updated_q    <= 1'b0;
      wr_dropped_q <= wr_en && (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: begin
          // A write in the commit cycle lands before the first SUM read.
          if (wr_en && wr_addr_ok) shadow_q[wr_addr] <= wr_data;
          if (commit) begin
            state_q        <= ST_SUM;
            commit_ready_q <= 1'b0;
          end
        end
        ST_SUM: begin
          if (sum_last) state_q <= ST_WAIT_SWAP;
        end
        ST_WAIT_SWAP: begin
          if (swap_enable) begin
            active_q       <= shadow_q;
            pb0_q          <= 8'd0 - sum_acc;
            updated_q      <= 1'b1;
            commit_ready_q <= 1'b1;
            state_q        <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [7:0] pb_w [0:PB_MAX];

  for (genvar n = 0; n <= PB_MAX; n++) begin : g_pb
    if (n == 0) begin : g_csum
      assign pb_w[n] = pb0_q;
    end else if (n <= int'(LENGTH)) begin : g_used
      assign pb_w[n] = active_q[n];
    end else begin : g_pad
      assign pb_w[n] = 8'h00;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_sub
    for (genvar j = 0; j < 7; j++) begin : g_byte
      assign sub[i][8*j +: 8] = pb_w[7*i + j];
    end
  end

  assign header       = infoframe_header(TYPE, VERSION, LENGTH);
  assign commit_ready = commit_ready_q;
  assign updated      = updated_q;
  assign wr_dropped   = wr_dropped_q;

endmodule

// File: tb/tb_infoframe_builder.sv
// Directed bench for infoframe_builder with TYPE=3, VERSION=1, LENGTH=25.
module tb_infoframe_builder;

  logic              clk_pixel = 1'b0;
  logic              reset_n;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [7:0]        wr_data;
  logic              commit;
  logic              commit_ready;
  logic              swap_enable;
  logic              wr_dropped;
  logic              updated;
  logic [23:0]       header;
  logic [3:0][55:0]  sub;

  int n_cmp = 0;
  int n_err = 0;

  infoframe_builder #(
    .TYPE    (7'd3),
    .VERSION (8'd1),
    .LENGTH  (5'd25)
  ) dut (
    .clk_pixel    (clk_pixel),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit       (commit),
    .commit_ready (commit_ready),
    .swap_enable  (swap_enable),
    .wr_dropped   (wr_dropped),
    .updated      (updated),
    .header       (header),
    .sub          (sub)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    logic [7:0] exp_pb;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  function automatic logic [7:0] pb_of(input int n);
    logic [55:0] w;
    w = sub[n / 7];
    return w[8 * (n % 7) +: 8];
  endfunction

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  // Edges counted from the one that samples commit; bounded so a stuck FSM cannot hang the run.
  task automatic wait_update(output int edges);
    edges = 1;
    while (updated !== 1'b1 && edges < 200) begin
      step();
      edges++;
    end
    check("updated_seen", {31'b0, updated}, 32'd1);
  endtask

  function automatic logic [7:0] total_sum();
    logic [7:0] s;
    s = 8'h83 + 8'h01 + 8'h19;
    for (int n = 0; n <= 27; n++) s = s + pb_of(n);
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int nz;
    int pulses;

    vecs[0] = '{5'd1, 8'h68, 8'h68};
    vecs[1] = '{5'd2, 8'h64, 8'h64};
    vecs[2] = '{5'd3, 8'h6C, 8'h6C};
    vecs[3] = '{5'd4, 8'h2D, 8'h2D};
    vecs[4] = '{5'd5, 8'h75, 8'h75};
    vecs[5] = '{5'd6, 8'h74, 8'h74};
    vecs[6] = '{5'd7, 8'h69, 8'h69};
    vecs[7] = '{5'd8, 8'h6C, 8'h6C};

    reset_n     = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    commit      = 1'b0;
    swap_enable = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Reset state
    check("rst_header", {8'h0, header}, 32'h190183);
    check("rst_pb0", {24'h0, pb_of(0)}, 32'h63);
    nz = 0;
    for (int n = 1; n <= 27; n++) if (pb_of(n) != 8'h00) nz++;
    check("rst_pb_rest_nonzero", nz, 0);
    check("rst_commit_ready", {31'b0, commit_ready}, 32'd1);
    check("rst_updated", {31'b0, updated}, 32'd0);
    check("rst_wr_dropped", {31'b0, wr_dropped}, 32'd0);

    // "hdl-util" into PB1..PB8, swap_enable high
    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].addr, vecs[i].data);
      check("t2_no_drop", {31'b0, wr_dropped}, 32'd0);
    end
    do_commit();
    check("t2_ready_low_c1", {31'b0, commit_ready}, 32'd0);
    check("t2_pb0_old_c1", {24'h0, pb_of(0)}, 32'h63);
    wait_update(edges);
    check("t2_latency", edges, 27);
    check("t2_ready_back", {31'b0, commit_ready}, 32'd1);
    check("t2_pb0", {24'h0, pb_of(0)}, 32'h40);
    check("t2_sub0_pb1", {24'h0, sub[0][15:8]}, 32'h68);
    for (int i = 0; i < 8; i++)
      check($sformatf("t2_pb%0d", vecs[i].addr), {24'h0, pb_of(int'(vecs[i].addr))}, {24'h0, vecs[i].exp_pb});
    check("t2_total_zero", {24'h0, total_sum()}, 32'h0);
    step();
    check("t2_updated_one_cycle", {31'b0, updated}, 32'd0);

    // Held swap: PB9=01, swap_enable low for WAIT_SWAP cycles C26..C35
    do_write(5'd9, 8'h01);
    swap_enable = 1'b0;
    do_commit();
    nz = 0;
    for (int k = 1; k <= 36; k++) begin
      if (updated !== 1'b0 || pb_of(0) != 8'h40 || pb_of(9) != 8'h00) nz++;
      if (k < 36) step();
    end
    check("t3_stable_while_held", nz, 0);
    swap_enable = 1'b1;
    step();
    check("t3_updated_after_high", {31'b0, updated}, 32'd1);
    check("t3_pb0", {24'h0, pb_of(0)}, 32'h3F);
    check("t3_pb9", {24'h0, pb_of(9)}, 32'h01);
    check("t3_total_zero", {24'h0, total_sum()}, 32'h0);

    // Write during SUM is dropped; commit during WAIT_SWAP is ignored
    step();
    swap_enable = 1'b0;
    do_commit();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    check("t4_dropped_pulse", {31'b0, wr_dropped}, 32'd1);
    step();
    check("t4_dropped_clear", {31'b0, wr_dropped}, 32'd0);
    repeat (23) step();
    check("t4_ready_low_wait", {31'b0, commit_ready}, 32'd0);
    do_commit();
    repeat (3) step();
    check("t4_no_update_held", {31'b0, updated}, 32'd0);
    swap_enable = 1'b1;
    step();
    check("t4_updated", {31'b0, updated}, 32'd1);
    check("t4_pb3_kept", {24'h0, pb_of(3)}, 32'h6C);
    check("t4_pb0", {24'h0, pb_of(0)}, 32'h3F);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (updated === 1'b1) pulses++;
    end
    check("t4_no_queued_commit", pulses, 0);
    check("t4_ready_idle", {31'b0, commit_ready}, 32'd1);

    // Out-of-range addresses are ignored silently
    do_write(5'd0, 8'h55);
    check("t5_addr0_no_drop", {31'b0, wr_dropped}, 32'd0);
    do_write(5'd26, 8'h11);
    do_write(5'd31, 8'h22);
    check("t5_addr31_no_drop", {31'b0, wr_dropped}, 32'd0);
    do_commit();
    wait_update(edges);
    check("t5_pb0", {24'h0, pb_of(0)}, 32'h3F);
    check("t5_pb26", {24'h0, pb_of(26)}, 32'h00);
    check("t5_pb27", {24'h0, pb_of(27)}, 32'h00);
    check("t5_total_zero", {24'h0, total_sum()}, 32'h0);
    step();

    // Reset in C5 of SUM aborts the update
    do_commit();
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    check("t6_async_ready", {31'b0, commit_ready}, 32'd1);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("t6_header", {8'h0, header}, 32'h190183);
    check("t6_pb0", {24'h0, pb_of(0)}, 32'h63);
    nz = 0;
    for (int n = 1; n <= 27; n++) if (pb_of(n) != 8'h00) nz++;
    check("t6_pb_rest_nonzero", nz, 0);
    check("t6_updated", {31'b0, updated}, 32'd0);
    do_commit();
    wait_update(edges);
    check("t6_latency", edges, 27);
    check("t6_pb0_empty", {24'h0, pb_of(0)}, 32'h63);
    check("t6_pb1_empty", {24'h0, pb_of(1)}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
